ram_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 1-cycle-latency synchronous RAM port among NUM_PORTS

---
 rtl/ram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Round-robin arbiter that shares one synchronous RAM port (1-cycle read
//   latency) among NUM_PORTS requesters. The winner's command is latched in
//   IDLE, issued in ISSUE, and for reads the returned word is captured in RESP
//   and presented with a one-cycle per-port rvalid pulse. Only one access is
//   in flight at a time.
//
//   Optional feature macro: ARB_HALT_DETECT_EN
//     When defined, a read that returns HALT_WORD parks the arbiter in HALT
//     (sticky halt flag, no further grants) until i_clear.
//     When undefined, HALT is unreachable and o_halt stays 0.
//
// Ports
//   i_clk        clock, rising edge
//   i_clear      asynchronous active-high reset
//   i_req        per-port request (level)
//   i_we         per-port write enable (1=write)
//   i_addr       per-port address, port i at [i*ADDR_W +: ADDR_W]
//   i_wdata      per-port write data, same packing
//   o_gnt        one-hot grant pulse, the cycle the access is issued
//   o_rvalid     one-hot read-data-valid pulse
//   o_rdata      read data, held between reads
//   o_busy       1 in any state other than IDLE
//   o_halt       sticky halt flag
//   o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata  RAM command
//   i_mem_rdata  RAM read data, valid the cycle after a read strobe
module ram_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}}
) (
  input  logic                          i_clk,
  input  logic                          i_clear,
  input  logic [NUM_PORTS-1:0]          i_req,
  input  logic [NUM_PORTS-1:0]          i_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   i_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   i_wdata,
  output logic [NUM_PORTS-1:0]          o_gnt,
  output logic [NUM_PORTS-1:0]          o_rvalid,
  output logic [DATA_W-1:0]             o_rdata,
  output logic                          o_busy,
  output logic                          o_halt,
  output logic                          o_mem_en,
  output logic                          o_mem_we,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic [DATA_W-1:0]             o_mem_wdata,
  input  logic [DATA_W-1:0]             i_mem_rdata
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_HALT} state_t;

  state_t                r_state, w_next;
  logic [PW-1:0]         r_ptr, r_win, w_win;
  logic                  r_we, w_any;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata, r_rdata;
  logic [NUM_PORTS-1:0]  r_rvalid, w_win_oh;
  logic                  r_halt, w_issue;

  // (a + k) mod NUM_PORTS, with k < NUM_PORTS
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return s[PW-1:0];
  endfunction

  // Scan from the farthest offset down to ptr so the nearest requester at or
  // after ptr is the last (winning) assignment.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (i_req[wrap_add(r_ptr, k)]) begin
        w_any = 1'b1;
        w_win = wrap_add(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_IDLE : S_RESP;
      S_RESP: begin
        w_next = S_IDLE;
`ifdef ARB_HALT_DETECT_EN
        if (i_mem_rdata == HALT_WORD) w_next = S_HALT;
`endif
      end
`ifdef ARB_HALT_DETECT_EN
      S_HALT:  w_next = S_HALT;
`else
      S_HALT:  w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= '0;
      r_halt   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= '0;
      if (r_state == S_IDLE && w_any) begin
        r_win   <= w_win;
        r_we    <= i_we[w_win];
        r_addr  <= i_addr[w_win*ADDR_W +: ADDR_W];
        r_wdata <= i_wdata[w_win*DATA_W +: DATA_W];
        r_ptr   <= wrap_add(w_win, 1);
      end
      if (r_state == S_RESP) begin
        r_rdata  <= i_mem_rdata;
        r_rvalid <= w_win_oh;
`ifdef ARB_HALT_DETECT_EN
        if (i_mem_rdata == HALT_WORD) r_halt <= 1'b1;
`endif
      end
    end
  end

  assign w_win_oh    = NUM_PORTS'(1) << r_win;
  assign w_issue     = (r_state == S_ISSUE);
  // Command outputs are combinational from state so clear kills them at once.
  assign o_mem_en    = w_issue;
  assign o_mem_we    = w_issue & r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_gnt       = w_issue ? w_win_oh : '0;
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = r_rdata;
  assign o_busy      = (r_state != S_IDLE);
  assign o_halt      = r_halt;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic clear;
  logic [N-1:0] req, we;
  logic [N-1:0][15:0] addr, wdata;
  logic [N-1:0] gnt, rvalid;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic busy, halt, mem_en, mem_we;
  logic [15:0] ram [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_PORTS(N), .ADDR_W(16), .DATA_W(16), .HALT_WORD(16'hFFFF)) dut (
    .i_clk(clk), .i_clear(clear), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_busy(busy), .o_halt(halt),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // 1-cycle-latency synchronous RAM model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic do_clear();
    clear = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    @(negedge clk); @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic drain();
    req = '0; we = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    clear = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    @(negedge clk);
    checks++;
    if ({gnt, rvalid, rdata, busy, halt, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b rvalid=%b rdata=%h busy=%b halt=%b en=%b we=%b addr=%h wd=%h exp all 0",
               gnt, rvalid, rdata, busy, halt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    clear = 1'b0;
  endtask

  task automatic test_single_read();
    do_clear();
    ram[8'h02] = 16'h8002;
    req = 4'b0001; we = '0; addr[0] = 16'h0002;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0002) begin
      errors++;
      $display("FAIL t1_issue got gnt=%b en=%b we=%b addr=%h exp 0001/1/0/0002", gnt, mem_en, mem_we, mem_addr);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || rvalid !== 4'b0000 || mem_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t1_resp got gnt=%b rvalid=%b en=%b busy=%b exp 0000/0000/0/1", gnt, rvalid, mem_en, busy);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0001 || rdata !== 16'h8002) begin
      errors++;
      $display("FAIL t1_rvalid got rvalid=%b rdata=%h exp 0001/8002", rvalid, rdata);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0000 || rdata !== 16'h8002 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_hold got rvalid=%b rdata=%h busy=%b exp 0000/8002/0", rvalid, rdata, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [5];
    int ngnt, last_cyc;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_clear();
    for (int i = 0; i < N; i++) addr[i] = 16'h0040 + 16'(i);
    we = '0; req = 4'b1111;
    ngnt = 0; last_cyc = 0;
    for (int c = 1; c <= 40 && ngnt < 5; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        checks++;
        if (gnt !== exp_seq[ngnt]) begin
          errors++;
          $display("FAIL rr_order[%0d] got gnt=%b exp %b", ngnt, gnt, exp_seq[ngnt]);
        end
        if (ngnt > 0) begin
          checks++;
          if (c - last_cyc != 3) begin
            errors++;
            $display("FAIL rr_spacing[%0d] got %0d cycles exp 3", ngnt, c - last_cyc);
          end
        end
        last_cyc = c;
        ngnt++;
      end
    end
    checks++;
    if (ngnt != 5) begin
      errors++;
      $display("FAIL rr_timeout got %0d grants exp 5", ngnt);
    end
    drain();
  endtask

  task automatic test_write_then_read();
    do_clear();
    req = 4'b0100; we = 4'b0100; addr[2] = 16'h0010; wdata[2] = 16'h1234;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h1234) begin
      errors++;
      $display("FAIL t3_write got gnt=%b we=%b addr=%h wd=%h exp 0100/1/0010/1234", gnt, mem_we, mem_addr, mem_wdata);
    end
    req = '0; we = '0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t3_after_write got we=%b en=%b busy=%b exp 0/0/0", mem_we, mem_en, busy);
    end
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL t3_read_issue got gnt=%b we=%b exp 0100/0", gnt, mem_we);
    end
    req = '0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (rvalid !== 4'b0100 || rdata !== 16'h1234) begin
      errors++;
      $display("FAIL t3_readback got rvalid=%b rdata=%h exp 0100/1234", rvalid, rdata);
    end
    // ptr now 3: with ports 0 and 3 both requesting, port 3 must win
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL t3_ptr got gnt=%b exp 1000", gnt);
    end
    drain();
  endtask

  task automatic test_req_pulse();
    int ng, nv;
    do_clear();
    req = 4'b0010; we = '0; addr[1] = 16'h0002;
    @(negedge clk);
    req = '0;
    ng = (gnt == 4'b0010) ? 1 : 0;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (gnt != '0) ng++;
      if (rvalid == 4'b0010) nv++;
    end
    checks++;
    if (ng != 1 || nv != 1) begin
      errors++;
      $display("FAIL t4_pulse got grants=%0d rvalids=%0d exp 1/1", ng, nv);
    end
  endtask

  task automatic test_halt();
    int ng;
    logic exp_h;
`ifdef ARB_HALT_DETECT_EN
    exp_h = 1'b1;
`else
    exp_h = 1'b0;
`endif
    do_clear();
    // writing the halt word must never halt
    req = 4'b0001; we = 4'b0001; addr[0] = 16'h0021; wdata[0] = 16'hFFFF;
    @(negedge clk);
    req = '0; we = '0;
    @(negedge clk);
    checks++;
    if (halt !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_write_ffff got halt=%b busy=%b exp 0/0", halt, busy);
    end
    ram[8'h20] = 16'hFFFF;
    req = 4'b1000; addr[3] = 16'h0020;
    @(negedge clk);
    req = '0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (rvalid !== 4'b1000 || rdata !== 16'hFFFF || halt !== exp_h || busy !== exp_h) begin
      errors++;
      $display("FAIL t5_read_ffff got rvalid=%b rdata=%h halt=%b busy=%b exp 1000/ffff/%b/%b",
               rvalid, rdata, halt, busy, exp_h, exp_h);
    end
    req = 4'b1111;
    ng = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (gnt != '0) ng++;
    end
    checks++;
    if ((ng == 0) !== exp_h) begin
      errors++;
      $display("FAIL t5_grants_after got %0d grants exp %s", ng, exp_h ? "0" : "nonzero");
    end
    do_clear();
    checks++;
    if (halt !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_clear got halt=%b busy=%b exp 0/0", halt, busy);
    end
    req = 4'b0001; we = '0; addr[0] = 16'h0002;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL t5_regrant got gnt=%b exp 0001", gnt);
    end
    drain();
  endtask

  task automatic test_clear_mid_write();
    do_clear();
    ram[8'h30] = 16'hAAAA;
    req = 4'b0010; we = 4'b0010; addr[1] = 16'h0030; wdata[1] = 16'h5555;
    @(posedge clk);
    #1;
    checks++;
    if (mem_en !== 1'b1 || gnt !== 4'b0010) begin
      errors++;
      $display("FAIL t6_issue got en=%b gnt=%b exp 1/0010", mem_en, gnt);
    end
    clear = 1'b1;
    #1;
    checks++;
    if ({gnt, rvalid, rdata, busy, halt, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL t6_async got gnt=%b en=%b we=%b addr=%h busy=%b exp all 0", gnt, mem_en, mem_we, mem_addr, busy);
    end
    req = '0; we = '0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (ram[8'h30] !== 16'hAAAA) begin
      errors++;
      $display("FAIL t6_ram got %h exp aaaa", ram[8'h30]);
    end
    clear = 1'b0;
    // ptr back at 0: port 0 beats port 3
    req = 4'b1001; addr[0] = 16'h0002; addr[3] = 16'h0002;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL t6_ptr got gnt=%b exp 0001", gnt);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i);
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_then_read();
    test_req_pulse();
    test_halt();
    test_clear_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
